// File: rtl/adder_bist_pkg.sv
// Shared types, widths and helper functions for the 3-bit adder self-test driver.
// Optional build macro used by the vector source: BIST_EXHAUSTIVE_EN.
package adder_bist_pkg;

   localparam int OPW  = 3;   // adder operand width
   localparam int IDXW = 10;  // vector index width
   localparam int ERRW = 8;   // error counter width
   localparam int SRCW = 7;   // vector source width: {a[2:0], b[2:0], cin}

   // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the shift register)
   localparam logic [SRCW-1:0] LFSR_TAPS = 7'b110_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } bist_state_e;

   // Reference result of the adder tile: {cout, sum}
   function automatic logic [OPW:0] golden_sum(input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b,
                                               input logic           cin);
      return {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin};
   endfunction

   // One Fibonacci step: shift towards the MSB, feedback enters at bit 0
   function automatic logic [SRCW-1:0] lfsr_next(input logic [SRCW-1:0] s);
      return {s[SRCW-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_vec_src.sv
// Operand vector source for the adder self-test.
// Default build: 7-bit Fibonacci LFSR (x^7+x^6+1) seeded with SEED.
// With BIST_EXHAUSTIVE_EN defined: 7-bit binary counter from 0 that wraps,
// covering all 128 operand combinations; SEED is then unused.
// vec presents the vector to issue this cycle; on load it is the start value,
// so the first vector of a run can be issued on the same edge as the reload.
module bist_vec_src
   import adder_bist_pkg::*;
#(
   parameter logic [SRCW-1:0] SEED = 7'h5A
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   output logic [SRCW-1:0] vec
);

`ifdef BIST_EXHAUSTIVE_EN
   localparam logic [SRCW-1:0] START_VAL = '0;
`else
   localparam logic [SRCW-1:0] START_VAL = SEED;
`endif

   logic [SRCW-1:0] r_state;
   logic [SRCW-1:0] w_next;

   assign vec = load ? START_VAL : r_state;

   // Successor of the vector being issued now
   always_comb begin
`ifdef BIST_EXHAUSTIVE_EN
      w_next = vec + 1'b1;
`else
      w_next = lfsr_next(vec);
`endif
   end

   // Source register: reload to start value, advance once per issued vector
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= START_VAL;
      end else if (step) begin
         r_state <= w_next;
      end else if (load) begin
         r_state <= START_VAL;
      end
   end

endmodule

// File: rtl/adder_bist_driver.sv
// On-chip self test for the 3-bit ripple adder tile: drives registered
// operands, delays a golden result alongside each vector by the adder's
// latency, and counts mismatches / records the first failing index.
// Optional build macro (vector source selection): BIST_EXHAUSTIVE_EN.
module adder_bist_driver
   import adder_bist_pkg::*;
#(
   parameter int unsigned     NUM_VECTORS = 1000,  // 1..1023
   parameter int unsigned     LATENCY     = 1,     // 0..7
   parameter logic [SRCW-1:0] LFSR_SEED   = 7'h5A
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [OPW-1:0]  op_a,
   output logic [OPW-1:0]  op_b,
   output logic            op_cin,
   input  logic [OPW-1:0]  dut_sum,
   input  logic            dut_cout,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_count,
   output logic [IDXW-1:0] first_err_idx
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VECTORS - 1);
   localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

   bist_state_e     r_state;
   bist_state_e     w_state_next;
   logic            w_issue;
   logic            w_src_load;
   logic [IDXW-1:0] w_issue_idx;
   logic [IDXW-1:0] r_idx;
   logic [SRCW-1:0] w_vec;

   logic [OPW-1:0]  r_op_a;
   logic [OPW-1:0]  r_op_b;
   logic            r_op_cin;

   // Golden pipeline: stage k holds the vector issued k edges ago
   logic [OPW:0]    r_exp  [0:LATENCY];
   logic [IDXW-1:0] r_pidx [0:LATENCY];
   logic            r_vld  [0:LATENCY];
   logic            w_pipe_pending;
   logic            w_mismatch;

   logic [ERRW-1:0] r_err;
   logic [IDXW-1:0] r_first;

   bist_vec_src #(
      .SEED (LFSR_SEED)
   ) u_src (
      .clk   (clk),
      .reset (reset),
      .load  (w_src_load),
      .step  (w_issue),
      .vec   (w_vec)
   );

   // Anything still in flight other than the stage being compared this cycle
   always_comb begin
      w_pipe_pending = 1'b0;
      for (int k = 0; k < int'(LATENCY); k++) begin
         w_pipe_pending = w_pipe_pending | r_vld[k];
      end
   end

   // Next-state and issue control; a start in IDLE/DONE issues vector 0 at once
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_src_load   = 1'b0;
      w_issue_idx  = r_idx;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_issue      = 1'b1;
               w_src_load   = 1'b1;
               w_issue_idx  = '0;
               w_state_next = (LAST_IDX == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            w_issue = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!w_pipe_pending) begin
               w_state_next = DONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register and vector index counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_issue) begin
            r_idx <= w_issue_idx + 1'b1;
         end
      end
   end

   // Registered operands toward the adder tile; they hold between runs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_op_cin <= 1'b0;
      end else if (w_issue) begin
         r_op_a   <= w_vec[6:4];
         r_op_b   <= w_vec[3:1];
         r_op_cin <= w_vec[0];
      end
   end

   // Pipeline entry: golden result and index of the vector issued this edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld[0]  <= 1'b0;
         r_exp[0]  <= '0;
         r_pidx[0] <= '0;
      end else begin
         r_vld[0] <= w_issue;
         if (w_issue) begin
            r_exp[0]  <= golden_sum(w_vec[6:4], w_vec[3:1], w_vec[0]);
            r_pidx[0] <= w_issue_idx;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi <= int'(LATENCY); gi++) begin : g_stage
         // Delay stage matching one register stage of the adder tile
         always_ff @(posedge clk) begin
            if (reset) begin
               r_vld[gi]  <= 1'b0;
               r_exp[gi]  <= '0;
               r_pidx[gi] <= '0;
            end else begin
               r_vld[gi]  <= r_vld[gi-1];
               r_exp[gi]  <= r_exp[gi-1];
               r_pidx[gi] <= r_pidx[gi-1];
            end
         end
      end
   endgenerate

   assign w_mismatch = r_vld[LATENCY] && ({dut_cout, dut_sum} != r_exp[LATENCY]);

   // Checker: saturating error count, index latched on the first error of a run
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err   <= '0;
         r_first <= '0;
      end else if (w_src_load) begin
         r_err   <= '0;
         r_first <= '0;
      end else if (w_mismatch) begin
         if (r_err == '0) begin
            r_first <= r_pidx[LATENCY];
         end
         if (r_err != ERR_MAX) begin
            r_err <= r_err + 1'b1;
         end
      end
   end

   assign op_a          = r_op_a;
   assign op_b          = r_op_b;
   assign op_cin        = r_op_cin;
   assign busy          = (r_state == RUN) || (r_state == DRAIN);
   assign done          = (r_state == DONE);
   assign pass          = done && (r_err == '0);
   assign err_count     = r_err;
   assign first_err_idx = r_first;

endmodule

// File: tb/tb_adder_bist_driver.sv
// Self-checking bench for adder_bist_driver: three instances with different
// vector counts / latencies, a faultable adder-tile model, and a run-level
// reference model that predicts every output after every clock edge.
module tb_adder_bist_driver;

   localparam int NI = 3;
   localparam int NV [NI] = '{10, 300, 37};
   localparam int LT [NI] = '{1, 0, 4};

   logic clk = 1'b0;
   logic reset;
   logic start;
   always #5 clk = ~clk;

   logic [2:0] opa [NI];
   logic [2:0] opb [NI];
   logic       opc [NI];
   logic [2:0] sum_in [NI];
   logic       cout_in [NI];
   logic       busy_o [NI];
   logic       done_o [NI];
   logic       pass_o [NI];
   logic [7:0] err_o [NI];
   logic [9:0] fidx_o [NI];

   adder_bist_driver #(.NUM_VECTORS(10), .LATENCY(1), .LFSR_SEED(7'h5A)) u_a (
      .clk(clk), .reset(reset), .start(start),
      .op_a(opa[0]), .op_b(opb[0]), .op_cin(opc[0]),
      .dut_sum(sum_in[0]), .dut_cout(cout_in[0]),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .err_count(err_o[0]), .first_err_idx(fidx_o[0]));

   adder_bist_driver #(.NUM_VECTORS(300), .LATENCY(0), .LFSR_SEED(7'h5A)) u_b (
      .clk(clk), .reset(reset), .start(start),
      .op_a(opa[1]), .op_b(opb[1]), .op_cin(opc[1]),
      .dut_sum(sum_in[1]), .dut_cout(cout_in[1]),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .err_count(err_o[1]), .first_err_idx(fidx_o[1]));

   adder_bist_driver #(.NUM_VECTORS(37), .LATENCY(4), .LFSR_SEED(7'h5A)) u_c (
      .clk(clk), .reset(reset), .start(start),
      .op_a(opa[2]), .op_b(opb[2]), .op_cin(opc[2]),
      .dut_sum(sum_in[2]), .dut_cout(cout_in[2]),
      .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
      .err_count(err_o[2]), .first_err_idx(fidx_o[2]));

   // ---------------- adder tile model with fault injection ----------------
   // mode 0 ideal, 1 sum[0] stuck at 0, 2 all outputs inverted, 3 random xor mask
   int         mode;
   logic [3:0] mask [NI];
   logic [3:0] tile [NI][8];
   logic [3:0] obs  [NI];

   function automatic logic [3:0] gsum(input logic [6:0] v);
      return 4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         tile[k][0] <= gsum({opa[k], opb[k], opc[k]});
         for (int s = 1; s < 8; s++) tile[k][s] <= tile[k][s-1];
      end
   end

   always_comb begin
      for (int k = 0; k < NI; k++) begin
         logic [3:0] t;
         if (LT[k] == 0) t = gsum({opa[k], opb[k], opc[k]});
         else            t = tile[k][LT[k]-1];
         obs[k] = t;
         case (mode)
            1:       obs[k] = t & 4'b1110;
            2:       obs[k] = ~t;
            3:       obs[k] = t ^ mask[k];
            default: obs[k] = t;
         endcase
      end
   end

   for (genvar g = 0; g < NI; g++) begin : g_tile_out
      assign sum_in[g]  = obs[g][2:0];
      assign cout_in[g] = obs[g][3];
   end

   // ---------------- reference model ----------------
   logic [6:0] vseq [300];
   bit         m_active [NI];
   bit         m_done [NI];
   int         m_t [NI];
   int         m_err [NI];
   int         m_first [NI];
   logic [6:0] m_op [NI];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int k, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s inst%0d: got %0d want %0d (t=%0t)", name, k, act, exp, $time);
      end
   endtask

   // State after the coming edge, from the inputs and tile outputs seen now
   task automatic predict();
      int j;
      for (int k = 0; k < NI; k++) begin
         if (reset) begin
            m_active[k] = 0; m_done[k] = 0; m_err[k] = 0; m_first[k] = 0; m_op[k] = '0;
         end else if (!m_active[k]) begin
            if (start) begin
               m_active[k] = 1; m_t[k] = 0; m_done[k] = 0;
               m_err[k] = 0; m_first[k] = 0; m_op[k] = vseq[0];
            end
         end else begin
            m_t[k]++;
            if (m_t[k] < NV[k]) m_op[k] = vseq[m_t[k]];
            j = m_t[k] - LT[k] - 1;
            if (j >= 0 && j < NV[k] && obs[k] != gsum(vseq[j])) begin
               if (m_err[k] == 0) m_first[k] = j;
               if (m_err[k] < 255) m_err[k]++;
            end
            if (m_t[k] == NV[k] + LT[k]) begin
               m_active[k] = 0;
               m_done[k]   = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk("busy",  k, int'(busy_o[k]), int'(m_active[k]));
         chk("done",  k, int'(done_o[k]), int'(m_done[k]));
         chk("pass",  k, int'(pass_o[k]), int'(m_done[k] && m_err[k] == 0));
         chk("err",   k, int'(err_o[k]),  m_err[k]);
         chk("first", k, int'(fidx_o[k]), m_first[k]);
         chk("op_a",  k, int'(opa[k]),    int'(m_op[k][6:4]));
         chk("op_b",  k, int'(opb[k]),    int'(m_op[k][3:1]));
         chk("op_cin",k, int'(opc[k]),    int'(m_op[k][0]));
      end
   endtask

   // One clock: drive at the falling edge, predict, check after the rising edge
   task automatic step(input logic st, input logic rs);
      reset = rs;
      start = st;
      for (int k = 0; k < NI; k++)
         mask[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      #1;
      predict();
      @(posedge clk);
      #2;
      check_all();
      $display("cyc t=%0t start=%0b reset=%0b busy=%0b%0b%0b done=%0b%0b%0b err=%0d/%0d/%0d",
               $time, st, rs, busy_o[0], busy_o[1], busy_o[2], done_o[0], done_o[1], done_o[2],
               err_o[0], err_o[1], err_o[2]);
      @(negedge clk);
   endtask

   task automatic wait_all(input int budget);
      int c = 0;
      while (!(done_o[0] && done_o[1] && done_o[2]) && c < budget) begin
         step(1'b0, 1'b0);
         c++;
      end
      chk("run_finish", 0, int'(done_o[0] && done_o[1] && done_o[2]), 1);
   endtask

   initial begin
      logic [6:0] s;
      int cycles, odd_cnt, odd_first;

      // Vector sequence straight from the source rules
      s = 7'h5A;
      for (int i = 0; i < 300; i++) begin
`ifdef BIST_EXHAUSTIVE_EN
         vseq[i] = 7'(i);
`else
         vseq[i] = s;
         s = {s[5:0], s[6] ^ s[5]};
`endif
      end
`ifdef BIST_EXHAUSTIVE_EN
      chk("pin_vec0",   0, int'(vseq[0]), 0);
      chk("pin_vec127", 0, int'(vseq[127]), 127);
      chk("pin_gold127",0, int'(gsum(vseq[127])), 15);
`else
      chk("pin_vec0",   0, int'(vseq[0]), 'h5A);
      chk("pin_vec1",   0, int'(vseq[1]), 'h35);
      chk("pin_gold0",  0, int'(gsum(vseq[0])), 10);
`endif

      mode  = 0;
      reset = 1'b1;
      start = 1'b0;
      for (int k = 0; k < NI; k++) mask[k] = '0;
      @(negedge clk);

      // Reset held three cycles, then quiet cycles with no start
      repeat (3) step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      for (int k = 0; k < NI; k++) begin
         chk("rst_busy", k, int'(busy_o[k]), 0);
         chk("rst_done", k, int'(done_o[k]), 0);
         chk("rst_opa",  k, int'(opa[k]), 0);
      end

      // Clean run: instance 0 finishes 11 edges after the start edge
      step(1'b1, 1'b0);
      chk("clean_busy", 0, int'(busy_o[0]), 1);
      chk("clean_op_a0", 0, int'(opa[0]), int'(vseq[0][6:4]));
      cycles = 0;
      while (!done_o[0] && cycles < 40) begin
         step(1'b0, 1'b0);
         cycles++;
      end
      chk("clean_done_edge", 0, cycles, 11);
      chk("clean_err",  0, int'(err_o[0]), 0);
      chk("clean_pass", 0, int'(pass_o[0]), 1);
      wait_all(400);

      // Stuck-at-0 on sum[0]: every odd golden sum fails
      mode = 1;
      step(1'b1, 1'b0);
      wait_all(400);
      for (int k = 0; k < NI; k++) begin
         odd_cnt = 0;
         odd_first = -1;
         for (int i = 0; i < NV[k]; i++) begin
            if (gsum(vseq[i]) % 2 == 1) begin
               odd_cnt++;
               if (odd_first < 0) odd_first = i;
            end
         end
         if (odd_cnt > 255) odd_cnt = 255;
         if (odd_first < 0) odd_first = 0;
         chk("stuck_err",   k, int'(err_o[k]), odd_cnt);
         chk("stuck_first", k, int'(fidx_o[k]), odd_first);
      end

      // Abort during vector 5, then replay from vector 0
      mode = 0;
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      chk("abort_pre_op_a", 0, int'(opa[0]), int'(vseq[5][6:4]));
      step(1'b0, 1'b1);
      for (int k = 0; k < NI; k++) begin
         chk("abort_busy", k, int'(busy_o[k]), 0);
         chk("abort_done", k, int'(done_o[k]), 0);
         chk("abort_op",   k, int'({opa[k], opb[k], opc[k]}), 0);
      end
      step(1'b1, 1'b0);
      chk("replay_op", 0, int'({opa[0], opb[0], opc[0]}), int'(vseq[0]));
      wait_all(400);

      // Inverted outputs: every vector fails, count saturates
      mode = 2;
      step(1'b1, 1'b0);
      wait_all(400);
      chk("sat_err",   1, int'(err_o[1]), 255);
      chk("sat_first", 1, int'(fidx_o[1]), 0);
      chk("sat_pass",  1, int'(pass_o[1]), 0);
      chk("inv_err",   0, int'(err_o[0]), 10);

      // Random starts, occasional resets, random sparse output corruption
      mode = 3;
      for (int n = 0; n < 2500; n++)
         step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
